// File: rtl/sample_packer_pkg.sv
// Shared constants for the sample packer and the host-side decoder.
//   DEF_SAMPLE_BYTES : bytes per sample word
//   DEF_SYNC_WORD    : re-alignment marker, sent with the same byte order as a sample
//   IDX_W            : width of the byte index inside a word
//   pk_state_e       : packer FSM encoding (IDLE=0, SEND=1)
package sample_packer_pkg;
  localparam int          DEF_SAMPLE_BYTES = 6;
  localparam logic [47:0] DEF_SYNC_WORD    = 48'hFFFF_FFFF_FFFF;
  localparam int          IDX_W            = 3;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } pk_state_e;
endpackage

// File: rtl/packer_shift_reg.sv
// Parallel-load, byte-shift-right register. Holds the word being serialised,
// presents its low byte, and tracks which byte of the word is on the output.
//   clk, reset : clock, synchronous active-high reset
//   load, din  : capture a new word (byte index restarts at 0)
//   shift      : the current byte was taken; advance to the next one
//   byte_out   : current byte (low byte of the register)
//   last       : current byte is the final byte of the word
module packer_shift_reg
  import sample_packer_pkg::*;
#(
  parameter int NBYTES = DEF_SAMPLE_BYTES
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                load,
  input  logic                shift,
  input  logic [8*NBYTES-1:0] din,
  output logic [7:0]          byte_out,
  output logic                last
);
  logic [8*NBYTES-1:0] shreg;
  logic [IDX_W-1:0]    idx;

  assign byte_out = shreg[7:0];
  assign last     = (idx == IDX_W'(NBYTES - 1));

  always_ff @(posedge clk) begin
    if (reset) begin
      shreg <= '0;
      idx   <= '0;
    end else if (load) begin
      shreg <= din;
      idx   <= '0;
    end else if (shift) begin
      // The last byte stays on the output; the next load replaces it.
      if (last) begin
        idx <= '0;
      end else begin
        shreg <= shreg >> 8;
        idx   <= idx + IDX_W'(1);
      end
    end
  end
endmodule

// File: rtl/sample_packer.sv
// Pops samples from a show-ahead FIFO and serialises each into bytes, LSB
// first, on a rdy/ack byte handshake. Optionally inserts a sync marker every
// SYNC_INTERVAL samples. Counts samples fully sent (markers excluded).
//   clk, reset            : clock, synchronous active-high reset
//   sample_rdy, sample    : FIFO not-empty and head word
//   sample_ack            : pop strobe, same cycle as the word is latched
//   sync_en               : enable marker insertion (0 also clears the interval count)
//   data_rdy, data        : output byte and its valid
//   data_ack              : consumer takes the byte this cycle
//   sample_count          : samples sent, wraps
module sample_packer
  import sample_packer_pkg::*;
#(
  parameter int                        SAMPLE_BYTES  = DEF_SAMPLE_BYTES,
  parameter int                        SYNC_INTERVAL = 1024,
  parameter logic [8*SAMPLE_BYTES-1:0] SYNC_WORD     = DEF_SYNC_WORD,
  parameter int                        COUNT_W       = 16
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      sample_rdy,
  input  logic [8*SAMPLE_BYTES-1:0] sample,
  output logic                      sample_ack,
  input  logic                      sync_en,
  output logic                      data_rdy,
  output logic [7:0]                data,
  input  logic                      data_ack,
  output logic [COUNT_W-1:0]        sample_count
);
  localparam int SC_W = $clog2(SYNC_INTERVAL + 1);

  pk_state_e                 state;
  logic                      is_sync;
  logic [SC_W-1:0]           sync_cnt;
  logic                      take_sync;
  logic                      xfer;
  logic                      load;
  logic                      last_byte;
  logic [8*SAMPLE_BYTES-1:0] load_word;

  // Marker wins over a waiting sample; the FIFO is only popped when a sample
  // is actually latched, so the pop strobe is combinational with the load.
  assign take_sync  = (state == IDLE) && sync_en && (sync_cnt == SC_W'(SYNC_INTERVAL));
  assign sample_ack = !reset && (state == IDLE) && !take_sync && sample_rdy;
  assign load       = take_sync || sample_ack;
  assign load_word  = take_sync ? SYNC_WORD : sample;
  assign xfer       = data_rdy && data_ack;

  packer_shift_reg #(.NBYTES(SAMPLE_BYTES)) u_sr (
    .clk      (clk),
    .reset    (reset),
    .load     (load),
    .shift    (xfer),
    .din      (load_word),
    .byte_out (data),
    .last     (last_byte)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      data_rdy     <= 1'b0;
      is_sync      <= 1'b0;
      sync_cnt     <= '0;
      sample_count <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (load) begin
            state    <= SEND;
            data_rdy <= 1'b1;
            is_sync  <= take_sync;
          end
        end
        SEND: begin
          if (xfer && last_byte) begin
            state    <= IDLE;
            data_rdy <= 1'b0;
            if (!is_sync) sample_count <= sample_count + COUNT_W'(1);
          end
        end
        default: begin
          state    <= IDLE;
          data_rdy <= 1'b0;
        end
      endcase

      // Interval counter: cleared while disabled or when a marker is taken,
      // bumped once per completed sample, saturating at the interval.
      if (!sync_en || take_sync)
        sync_cnt <= '0;
      else if ((state == SEND) && xfer && last_byte && !is_sync &&
               (sync_cnt != SC_W'(SYNC_INTERVAL)))
        sync_cnt <= sync_cnt + SC_W'(1);
    end
  end
endmodule

// File: tb/tb_sample_packer.sv
module tb_sample_packer;
  localparam int CW = 8;  // narrow count so the wrap is reachable quickly

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          sample_rdy = 1'b0;
  logic [47:0]   sample = '0;
  logic          sync_en = 1'b0;
  logic          data_ack = 1'b0;
  logic          sample_ack;
  logic          data_rdy;
  logic [7:0]    data;
  logic [CW-1:0] sample_count;

  sample_packer #(.SYNC_INTERVAL(2), .COUNT_W(CW)) dut (
    .clk          (clk),
    .reset        (reset),
    .sample_rdy   (sample_rdy),
    .sample       (sample),
    .sample_ack   (sample_ack),
    .sync_en      (sync_en),
    .data_rdy     (data_rdy),
    .data         (data),
    .data_ack     (data_ack),
    .sample_count (sample_count)
  );

  always #5 clk = ~clk;

  logic [47:0] fifo_q[$];
  logic [7:0]  exp_q[$];
  int          n_chk = 0;
  int          n_fail = 0;
  int          n_xfer = 0;
  int          n_acks = 0;
  bit          ack_seen = 1'b0;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  function automatic void refresh();
    sample_rdy = (fifo_q.size() != 0);
    sample     = sample_rdy ? fifo_q[0] : '0;
  endfunction

  function automatic void push_fifo(input logic [47:0] s);
    fifo_q.push_back(s);
    refresh();
  endfunction

  function automatic void push_exp(input logic [47:0] w);
    for (int i = 0; i < 6; i++) exp_q.push_back(w[8*i +: 8]);
  endfunction

  // Scoreboard side: every accepted byte is popped and compared.
  always @(negedge clk) begin
    logic [7:0] e;
    ack_seen = sample_ack;
    if (sample_ack) begin
      n_acks++;
      chk("ack_needs_rdy", sample_rdy, 1);
    end
    if (data_rdy && data_ack) begin
      n_xfer++;
      e = 'x;
      if (exp_q.size() != 0) e = exp_q.pop_front();
      chk("byte", data, e);
    end
  end

  // FIFO model: the head advances just after the edge that saw the pop.
  always @(posedge clk) begin
    #1;
    if (ack_seen && fifo_q.size() != 0) begin
      void'(fifo_q.pop_front());
      refresh();
    end
    ack_seen = 1'b0;
  end

  // Call at posedge+2; leaves the bench at posedge+2 with reset released.
  task automatic do_reset();
    reset = 1'b1;
    data_ack = 1'b0;
    exp_q.delete();
    fifo_q.delete();
    refresh();
    @(posedge clk); #2;
    @(negedge clk);
    chk("rst_data_rdy", data_rdy, 0);
    chk("rst_count", sample_count, 0);
    chk("rst_data", data, 0);
    chk("rst_ack", sample_ack, 0);
    @(posedge clk); #2;
    reset = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int budget);
    int k = 0;
    while (exp_q.size() != 0 && k < budget) begin
      @(posedge clk); #2;
      k++;
    end
    chk(tag, exp_q.size() == 0, 1);
  endtask

  initial begin
    int b_x, b_a, k;
    @(posedge clk); #2;
    do_reset();

    // 1: single sample, full rate
    data_ack = 1'b1;
    b_a = n_acks;
    push_fifo(48'h0605_0403_0201);
    push_exp(48'h0605_0403_0201);
    @(negedge clk);
    chk("t1_ack_first", sample_ack, 1);
    chk("t1_rdy_first", data_rdy, 0);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("t1_rdy_burst", data_rdy, 1);
    end
    @(negedge clk);
    chk("t1_bubble", data_rdy, 0);
    chk("t1_count", sample_count, 1);
    chk("t1_acks", n_acks - b_a, 1);
    @(posedge clk); #2;

    // 2: backpressure on byte 02
    data_ack = 1'b0;
    b_a = n_acks;
    push_fifo(48'h0605_0403_0201);
    push_exp(48'h0605_0403_0201);
    k = 0;
    do begin @(negedge clk); k++; end while (!data_rdy && k < 20);
    chk("t2_rdy_timeout", data_rdy, 1);
    @(posedge clk); #2; data_ack = 1'b1;
    @(posedge clk); #2; data_ack = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("t2_hold_data", data, 8'h02);
      chk("t2_hold_rdy", data_rdy, 1);
      chk("t2_no_ack", sample_ack, 0);
    end
    @(posedge clk); #2; data_ack = 1'b1;
    wait_done("t2_done", 20);
    chk("t2_count", sample_count, 2);
    chk("t2_acks", n_acks - b_a, 1);

    // 3: sync marker after two samples
    do_reset();
    sync_en = 1'b1;
    data_ack = 1'b1;
    b_a = n_acks;
    push_fifo(48'hA5A4_A3A2_A1A0);
    push_fifo(48'hB5B4_B3B2_B1B0);
    push_fifo(48'hC5C4_C3C2_C1C0);
    push_exp(48'hA5A4_A3A2_A1A0);
    push_exp(48'hB5B4_B3B2_B1B0);
    push_exp(48'hFFFF_FFFF_FFFF);
    push_exp(48'hC5C4_C3C2_C1C0);
    wait_done("t3_done", 60);
    chk("t3_count", sample_count, 3);
    chk("t3_acks", n_acks - b_a, 3);
    sync_en = 1'b0;

    // 4: empty FIFO, stray data_ack ignored
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #2;
      data_ack = 1'($urandom_range(0, 1));
      @(negedge clk);
      chk("t4_rdy", data_rdy, 0);
      chk("t4_ack", sample_ack, 0);
    end
    @(posedge clk); #2;

    // 5: reset after three bytes of a word
    data_ack = 1'b1;
    b_x = n_xfer;
    push_fifo(48'h0C0B_0A09_0807);
    push_exp(48'h0C0B_0A09_0807);
    k = 0;
    while (n_xfer - b_x < 3 && k < 30) begin
      @(posedge clk); #2;
      k++;
    end
    chk("t5_three_bytes", n_xfer - b_x, 3);
    do_reset();
    chk("t5_no_more_bytes", n_xfer - b_x, 3);
    data_ack = 1'b1;
    push_fifo(48'h1C1B_1A19_1817);
    push_exp(48'h1C1B_1A19_1817);
    wait_done("t5_done", 20);
    chk("t5_count", sample_count, 1);

    // 6: counter wrap (2^CW + 1 samples)
    do_reset();
    data_ack = 1'b1;
    b_x = n_xfer;
    b_a = n_acks;
    for (int i = 0; i < (1 << CW) + 1; i++) begin
      logic [47:0] s;
      s = {16'($urandom), 32'($urandom)};
      push_fifo(s);
      push_exp(s);
    end
    wait_done("t6_done", ((1 << CW) + 1) * 7 + 50);
    chk("t6_count_wrap", sample_count, 1);
    chk("t6_xfers", n_xfer - b_x, 6 * ((1 << CW) + 1));
    chk("t6_acks", n_acks - b_a, (1 << CW) + 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
